// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the exception path.
//   - ExcCode values written into Cause
//   - exception handler entry address
//   - exception controller FSM state type
package mips_pkg;

    localparam int          DATA_W     = 32;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;
    localparam logic [4:0]  CAUSE_RI   = 5'd10;  // reserved/invalid instruction
    localparam logic [4:0]  CAUSE_OV   = 5'd12;  // arithmetic overflow

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_HANDLER  = 2'd2,
        ST_RETURN   = 2'd3
    } exc_state_e;

endpackage

// File: rtl/cp0_regs.sv
// cp0_regs: coprocessor-0 register slice used by the exception unit.
//   clk, rst      : clock, synchronous active-high reset
//   load_en       : capture epc_in/cause_in this cycle
//   epc_in        : faulting PC to capture
//   cause_in      : ExcCode to capture
//   fault_set     : set the sticky double-fault flag
//   epc_out       : captured EPC
//   cause_out     : captured ExcCode
//   double_fault  : sticky flag, cleared only by reset
module cp0_regs
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [DATA_W-1:0] epc_in,
    input  logic [4:0]        cause_in,
    input  logic              fault_set,
    output logic [DATA_W-1:0] epc_out,
    output logic [4:0]        cause_out,
    output logic              double_fault
);

    logic [DATA_W-1:0] epc_d, epc_q;
    logic [4:0]        cause_d, cause_q;
    logic              df_d, df_q;

    // NOTE: every variable gets a hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        epc_d   = epc_q;
        cause_d = cause_q;
        df_d    = df_q | fault_set;
        if (load_en) begin
            epc_d   = epc_in;
            cause_d = cause_in;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            epc_q   <= '0;
            cause_q <= '0;
            df_q    <= 1'b0;
        end else begin
            epc_q   <= epc_d;
            cause_q <= cause_d;
            df_q    <= df_d;
        end
    end

    assign epc_out      = epc_q;
    assign cause_out    = cause_q;
    assign double_fault = df_q;

endmodule

// File: rtl/exception_unit.sv
// exception_unit: captures ID invalid-opcode / EX overflow exceptions,
// redirects fetch to the handler vector, masks exceptions until eret,
// then redirects fetch back to EPC.
//   clk, rst      : clock, synchronous active-high reset
//   id_invalid    : invalid opcode in ID      id_pc : PC of ID instruction
//   ex_overflow   : ALU overflow in EX        ex_pc : PC of EX instruction
//   eret          : return-from-exception decoded in ID
//   exc_pc_sel    : PC mux selects exc_pc     exc_pc: redirect target (0 when unused)
//   if_flush      : squash IF/ID              busy  : handler in progress
//   epc_out, cause_out, double_fault : CP0 register contents
module exception_unit
    import mips_pkg::*;
#(
    parameter int                DATA_W     = mips_pkg::DATA_W,
    parameter logic [DATA_W-1:0] EXC_VECTOR = mips_pkg::EXC_VECTOR,
    parameter logic [4:0]        CAUSE_RI   = mips_pkg::CAUSE_RI,
    parameter logic [4:0]        CAUSE_OV   = mips_pkg::CAUSE_OV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_invalid,
    input  logic              ex_overflow,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic              eret,
    output logic              exc_pc_sel,
    output logic [DATA_W-1:0] exc_pc,
    output logic              if_flush,
    output logic              busy,
    output logic [DATA_W-1:0] epc_out,
    output logic [4:0]        cause_out,
    output logic              double_fault
);

    exc_state_e        state_d, state_q;
    logic              load_en;
    logic              fault_set;
    logic [DATA_W-1:0] epc_in;
    logic [4:0]        cause_in;

    // Next-state and CP0 write control.
    always_comb begin
        state_d   = state_q;
        load_en   = 1'b0;
        fault_set = 1'b0;
        epc_in    = ex_pc;
        cause_in  = CAUSE_OV;
        unique case (state_q)
            ST_IDLE: begin
                // Overflow belongs to the older instruction, so it wins.
                if (ex_overflow) begin
                    load_en = 1'b1;
                    state_d = ST_REDIRECT;
                end else if (id_invalid) begin
                    load_en  = 1'b1;
                    epc_in   = id_pc;
                    cause_in = CAUSE_RI;
                    state_d  = ST_REDIRECT;
                end
            end
            ST_REDIRECT: state_d = ST_HANDLER;
            ST_HANDLER: begin
                fault_set = id_invalid | ex_overflow;
                if (eret) state_d = ST_RETURN;
            end
            // Anything sampled here comes from flushed instructions.
            ST_RETURN: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        exc_pc_sel = 1'b0;
        exc_pc     = '0;
        if_flush   = 1'b0;
        busy       = 1'b0;
        unique case (state_q)
            ST_REDIRECT: begin
                exc_pc_sel = 1'b1;
                exc_pc     = EXC_VECTOR;
                if_flush   = 1'b1;
                busy       = 1'b1;
            end
            ST_HANDLER: busy = 1'b1;
            ST_RETURN: begin
                exc_pc_sel = 1'b1;
                exc_pc     = epc_out;
                if_flush   = 1'b1;
                busy       = 1'b1;
            end
            default: ;
        endcase
    end

    cp0_regs #(.DATA_W(DATA_W)) u_cp0_regs (
        .clk          (clk),
        .rst          (rst),
        .load_en      (load_en),
        .epc_in       (epc_in),
        .cause_in     (cause_in),
        .fault_set    (fault_set),
        .epc_out      (epc_out),
        .cause_out    (cause_out),
        .double_fault (double_fault)
    );

endmodule

// File: tb/tb_exception_unit.sv
// tb_exception_unit: directed stimulus for exception_unit, checked every
// cycle against a transaction-level model plus hand-computed literals.
module tb_exception_unit;

    localparam logic [31:0] VEC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_invalid, ex_overflow, eret;
    logic [31:0] id_pc, ex_pc;
    logic        exc_pc_sel, if_flush, busy, double_fault;
    logic [31:0] exc_pc, epc_out;
    logic [4:0]  cause_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exception_unit dut (
        .clk          (clk),
        .rst          (rst),
        .id_invalid   (id_invalid),
        .ex_overflow  (ex_overflow),
        .id_pc        (id_pc),
        .ex_pc        (ex_pc),
        .eret         (eret),
        .exc_pc_sel   (exc_pc_sel),
        .exc_pc       (exc_pc),
        .if_flush     (if_flush),
        .busy         (busy),
        .epc_out      (epc_out),
        .cause_out    (cause_out),
        .double_fault (double_fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a redirect is either "pending this cycle" toward a target, and
    // the handler is either running or not. Architectural registers are
    // plain variables.
    bit          m_redirect, m_to_epc, m_in_handler, m_df;
    logic [31:0] m_target, m_epc;
    logic [4:0]  m_cause;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_redirect = 0; m_to_epc = 0; m_in_handler = 0; m_df = 0;
            m_target = 0; m_epc = 0; m_cause = 0;
        end else if (m_redirect) begin
            // vector redirect enters the handler; return redirect leaves it
            m_in_handler = !m_to_epc;
            m_redirect   = 0;
            m_to_epc     = 0;
        end else if (m_in_handler) begin
            if (id_invalid || ex_overflow) m_df = 1;
            if (eret) begin
                m_in_handler = 0;
                m_redirect   = 1;
                m_to_epc     = 1;
                m_target     = m_epc;
            end
        end else if (ex_overflow) begin
            m_epc = ex_pc; m_cause = 5'd12; m_redirect = 1; m_target = VEC;
        end else if (id_invalid) begin
            m_epc = id_pc; m_cause = 5'd10; m_redirect = 1; m_target = VEC;
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_sel",   {31'd0, exc_pc_sel},   {31'd0, m_redirect});
            check("m_pc",    exc_pc,                m_redirect ? m_target : 32'd0);
            check("m_flush", {31'd0, if_flush},     {31'd0, m_redirect});
            check("m_busy",  {31'd0, busy},         {31'd0, m_redirect | m_in_handler});
            check("m_epc",   epc_out,               m_epc);
            check("m_cause", {27'd0, cause_out},    {27'd0, m_cause});
            check("m_df",    {31'd0, double_fault}, {31'd0, m_df});
        end
    end

    // Apply inputs for one rising edge, then return the bus to idle.
    task automatic cyc(input logic r, input logic inv, input logic [31:0] ipc,
                       input logic ov, input logic [31:0] epc, input logic er);
        rst = r; id_invalid = inv; id_pc = ipc; ex_overflow = ov; ex_pc = epc; eret = er;
        @(posedge clk);
        #1;
        rst = 0; id_invalid = 0; id_pc = 0; ex_overflow = 0; ex_pc = 0; eret = 0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; id_invalid = 0; ex_overflow = 0; id_pc = 0; ex_pc = 0; eret = 0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_sel",   {31'd0, exc_pc_sel}, 32'd0);
        check("rst_pc",    exc_pc, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_epc",   epc_out, 32'd0);

        // Invalid opcode only, short handler.
        cyc(0, 1, 32'h0040_0010, 0, 32'h0000_0bad, 0);
        @(negedge clk);
        check("ri_sel",   {31'd0, exc_pc_sel}, 32'd1);
        check("ri_pc",    exc_pc, 32'h8000_0180);
        check("ri_flush", {31'd0, if_flush}, 32'd1);
        check("ri_epc",   epc_out, 32'h0040_0010);
        check("ri_cause", {27'd0, cause_out}, 32'd10);
        idle();
        cyc(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("ri_ret_pc", exc_pc, 32'h0040_0010);
        idle();
        @(negedge clk);
        check("ri_idle_busy", {31'd0, busy}, 32'd0);

        // Overflow only, three handler cycles, then eret.
        cyc(0, 0, 0, 1, 32'h0040_0020, 0);
        @(negedge clk);
        check("ov_pc",    exc_pc, 32'h8000_0180);
        check("ov_epc",   epc_out, 32'h0040_0020);
        check("ov_cause", {27'd0, cause_out}, 32'd12);
        idle(); idle(); idle();
        @(negedge clk);
        check("ov_h3_busy", {31'd0, busy}, 32'd1);
        check("ov_h3_sel",  {31'd0, exc_pc_sel}, 32'd0);
        cyc(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("ov_ret_sel",   {31'd0, exc_pc_sel}, 32'd1);
        check("ov_ret_pc",    exc_pc, 32'h0040_0020);
        check("ov_ret_flush", {31'd0, if_flush}, 32'd1);
        idle();
        @(negedge clk);
        check("ov_done_busy", {31'd0, busy}, 32'd0);

        // eret in IDLE does nothing.
        cyc(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("eret_idle_sel", {31'd0, exc_pc_sel}, 32'd0);

        // Simultaneous exceptions, then a nested overflow in the handler.
        cyc(0, 1, 32'h0000_0028, 1, 32'h0000_0024, 0);
        @(negedge clk);
        check("sim_epc",   epc_out, 32'h0000_0024);
        check("sim_cause", {27'd0, cause_out}, 32'd12);
        idle();
        cyc(0, 0, 0, 1, 32'h0000_0099, 0);
        @(negedge clk);
        check("nest_df",    {31'd0, double_fault}, 32'd1);
        check("nest_epc",   epc_out, 32'h0000_0024);
        check("nest_busy",  {31'd0, busy}, 32'd1);
        cyc(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("nest_ret_pc", exc_pc, 32'h0000_0024);
        idle();
        @(negedge clk);
        check("nest_df_sticky", {31'd0, double_fault}, 32'd1);

        // eret + exception together in HANDLER; exception during RETURN ignored.
        cyc(0, 1, 32'h0000_0100, 0, 0, 0);
        idle();
        cyc(0, 0, 0, 1, 32'h0000_0300, 1);
        @(negedge clk);
        check("ew_ret_pc", exc_pc, 32'h0000_0100);
        cyc(0, 1, 32'h0000_0200, 0, 0, 0);
        @(negedge clk);
        check("ret_ign_sel", {31'd0, exc_pc_sel}, 32'd0);
        check("ret_ign_epc", epc_out, 32'h0000_0100);

        // Reset while in HANDLER.
        cyc(0, 1, 32'h0000_0400, 0, 0, 0);
        idle();
        cyc(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("mr_sel",  {31'd0, exc_pc_sel}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_epc",  epc_out, 32'd0);
        check("mr_df",   {31'd0, double_fault}, 32'd0);
        idle();
        @(negedge clk);
        check("mr_noredir", {31'd0, exc_pc_sel}, 32'd0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
